// File: rtl/wb_arbiter_if.sv
// Bus bundle for wb_arbiter: ALU write port, load handshake, register-file
// write port, occupancy and forwarding lookup. The arbiter uses the slave
// modport; whatever drives ALU/load traffic uses the master modport.
interface wb_arbiter_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 11,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          alu_we;
  logic [AW-1:0] alu_waddr;
  logic [DW-1:0] alu_wdata;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_waddr;
  logic [DW-1:0] ld_wdata;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [CW-1:0] q_count;
  logic [AW-1:0] fwd_raddr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  modport slave (
    input  alu_we, alu_waddr, alu_wdata,
    input  ld_valid, ld_waddr, ld_wdata,
    input  fwd_raddr,
    output ld_ready, we, waddr, wdata, q_count, fwd_hit, fwd_data
  );

  modport master (
    output alu_we, alu_waddr, alu_wdata,
    output ld_valid, ld_waddr, ld_wdata,
    output fwd_raddr,
    input  ld_ready, we, waddr, wdata, q_count, fwd_hit, fwd_data
  );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter. ALU results always win the write port;
// load results wait in a DEPTH-entry FIFO and drain when the ALU is idle.
// An ALU write to a register kills (marks dead) every queued load aimed at
// the same register, since the ALU result is younger. Dead entries are
// still popped, but produce no write.
// Optional forwarding lookup over live queued entries is compiled only
// when the macro WB_ARBITER_FWD_EN is defined; otherwise fwd_hit/fwd_data
// are tied to zero.
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 11,
  parameter int DW    = 32
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0] live;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          we_q;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] wdata_q;

  logic full;
  logic ld_ready;
  logic push;
  logic pop;
  logic alu_hit;
  logic new_live;

  // Acceptance depends only on occupancy (not on a same-cycle pop) and is
  // held low while reset is asserted.
  assign full     = (count == CW'(DEPTH));
  assign ld_ready = rst & ~full;
  assign push     = bus.ld_valid & ld_ready;

  // Writes to register 0 are discarded, so they neither win the port nor
  // kill queued loads.
  assign alu_hit  = bus.alu_we & (bus.alu_waddr != '0);
  assign pop      = ~alu_hit & (count != '0);

  // A load to r0 is enqueued dead; so is a load killed by a same-cycle ALU
  // write to the same register.
  assign new_live = (bus.ld_waddr != '0) &
                    ~(alu_hit & (bus.ld_waddr == bus.alu_waddr));

  // Queue pointers and occupancy; power-of-two depth lets pointers wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue payload storage; contents are meaningless outside the live window.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= bus.ld_waddr;
      data_mem[tail] <= bus.ld_wdata;
    end
  end

  // Live bits: set on enqueue, cleared by a matching ALU write or on pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (tail == PW'(i))) begin
          live[i] <= new_live;
        end else if (alu_hit && (addr_mem[i] == bus.alu_waddr)) begin
          live[i] <= 1'b0;
        end else if (pop && (head == PW'(i))) begin
          live[i] <= 1'b0;
        end
      end
    end
  end

  // Registered write port: ALU first, then a live head; otherwise idle with
  // address/data held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (alu_hit) begin
      we_q    <= 1'b1;
      waddr_q <= bus.alu_waddr;
      wdata_q <= bus.alu_wdata;
    end else if (pop && live[head]) begin
      we_q    <= 1'b1;
      waddr_q <= addr_mem[head];
      wdata_q <= data_mem[head];
    end else begin
      we_q    <= 1'b0;
    end
  end

  assign bus.ld_ready = ld_ready;
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
  assign bus.q_count  = count;

`ifdef WB_ARBITER_FWD_EN
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  // Scan oldest to youngest so the youngest live match is left standing.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    if (bus.fwd_raddr != '0) begin
      for (int k = 0; k < DEPTH; k++) begin
        idx = head + PW'(k);
        if ((CW'(k) < count) && live[idx] && (addr_mem[idx] == bus.fwd_raddr)) begin
          fwd_hit  = 1'b1;
          fwd_data = data_mem[idx];
        end
      end
    end
  end

  assign bus.fwd_hit  = fwd_hit;
  assign bus.fwd_data = fwd_data;
`else
  logic unused_fwd_raddr;
  assign unused_fwd_raddr = ^bus.fwd_raddr;
  assign bus.fwd_hit  = 1'b0;
  assign bus.fwd_data = '0;
`endif

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 SHALL have parameter AW, default 11, register address width.
REQ-003 SHALL have parameter DW, default 32, register data width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port alu_we  input  1  ALU result valid this cycle; no backpressure.
REQ-007 SHALL have port alu_waddr  input  AW  ALU destination register.
REQ-008 SHALL have port alu_wdata  input  DW  ALU result.
REQ-009 SHALL have port ld_valid  input  1  load result offered.
REQ-010 SHALL have port ld_ready  output  1  load result accepted when ld_valid&ld_ready.
REQ-011 SHALL have port ld_waddr  input  AW  load destination register.
REQ-012 SHALL have port ld_wdata  input  DW  load data.
REQ-013 SHALL have port we  output  1  register-file write enable (registered).
REQ-014 SHALL have port waddr  output  AW  register-file write address (registered).
REQ-015 SHALL have port wdata  output  DW  register-file write data (registered).
REQ-016 SHALL have port q_count  output  log2(DEPTH)+1  live+dead queue occupancy.
REQ-017 SHALL have port fwd_raddr  input  AW  forwarding lookup address.
REQ-018 SHALL have port fwd_hit  output  1  lookup matched a live queued entry (combinational).
REQ-019 SHALL have port fwd_data  output  DW  data of youngest matching live entry, else 0.

Function
REQ-020 SHALL accept a load when ld_valid=1 and q_count<DEPTH; ld_ready=(q_count<DEPTH), independent of same-cycle pop.
REQ-021 SHALL store accepted loads in a FIFO of DEPTH entries {addr, data, live}; pointers wrap modulo DEPTH.
REQ-022 SHALL enqueue a load with ld_waddr=0 as dead (live=0).
REQ-023 SHALL, when alu_we=1 and alu_waddr!=0, drive we=1, waddr=alu_waddr, wdata=alu_wdata on the next edge (ALU priority, 1-cycle latency).
REQ-024 SHALL, when alu_we=1 and alu_waddr!=0, clear live on every queued entry with matching addr, including a load accepted in the same cycle (ALU treated as younger).
REQ-025 SHALL, when no qualifying ALU write and queue non-empty, pop the head; if head live, drive we=1/waddr/wdata from head next edge, else we=0.
REQ-026 SHALL pop at most one entry per cycle; push and pop in the same cycle leave q_count unchanged.
REQ-027 SHALL drive we=0 (waddr, wdata hold last value) in cycles with no ALU write and no live pop.
REQ-028 SHALL never assert we with waddr=0.
REQ-029 SHALL compute fwd_hit/fwd_data over live entries only, youngest wins; fwd_raddr=0 gives fwd_hit=0, fwd_data=0.

Reset
REQ-030 SHALL, on rst=0 at any time, immediately clear we, waddr, wdata, both pointers, q_count and all live bits; queued loads are discarded.
REQ-031 SHALL hold ld_ready=0 while rst=0 and resume normal operation on the first edge after rst=1.

Configuration
REQ-032 SHALL compile the forwarding lookup only when macro WB_ARBITER_FWD_EN is defined.
REQ-033 SHALL, without WB_ARBITER_FWD_EN, tie fwd_hit=0 and fwd_data=0 and ignore fwd_raddr; all other behaviour identical.

Verification
REQ-034 SHALL cover: alu_we=1, addr 5, data 0x11 with empty queue -> next cycle we=1, waddr=5, wdata=0x11.
REQ-035 SHALL cover: 4 loads (addr 1..4, data 0xA1..0xA4) while alu_we=1 continuously -> ld_ready=0 after fourth, q_count=4; alu_we drops -> writes 1..4 in order over 4 cycles, q_count=0.
REQ-036 SHALL cover: queued load addr 7 data 0xB0, then ALU write addr 7 data 0xC0 -> single write of 0xC0; dead entry popped with we=0; fwd_hit for addr 7 drops after ALU cycle.
REQ-037 SHALL cover: loads addr 9 data 0x1 then addr 9 data 0x2 queued, fwd_raddr=9 -> fwd_hit=1, fwd_data=0x2; fwd_raddr=0 -> fwd_hit=0.
REQ-038 SHALL cover: load addr 0 accepted -> q_count increments, popped with we=0, never written.
REQ-039 SHALL cover: rst=0 asserted mid-drain with q_count=3 -> we=0, q_count=0 asynchronously; no further writes after release.
